bus_rr: RTL
===========

BUS_RR -- requirements
Module: bus_rr

Interface
REQ-001 SHALL have parameter N_MASTER, default 4, number of bus masters (2..8).
REQ-002 SHALL have parameter N_SLAVE, default 4, number of slave windows (1..8).
REQ-003 SHALL have parameter ADDR_W, default 8, address width.
REQ-004 SHALL have parameter DATA_W, default 32, data width.
REQ-005 SHALL have parameter SLV_LSB, default 5, log2 of slave window size in words.
REQ-006 SHALL have parameter MAX_HOLD, default 16, hold-limit cycles (used only under BUS_RR_TIMEOUT_EN).
REQ-007 clk  input  1  single clock, all state updates on rising edge.
REQ-008 reset  input  1  synchronous, active-high reset.
REQ-009 M_req  input  N_MASTER  per-master bus request.
REQ-010 M_wr  input  N_MASTER  per-master write enable (1 = write).
REQ-011 M_address  input  N_MASTER*ADDR_W  packed master addresses; master i at bits [i*ADDR_W +: ADDR_W].
REQ-012 M_dout  input  N_MASTER*DATA_W  packed master write data.
REQ-013 M_grant  output  N_MASTER  one-hot or zero grant vector (registered).
REQ-014 M_din  output  DATA_W  read data returned to the masters.
REQ-015 S_sel  output  N_SLAVE  one-hot or zero slave select.
REQ-016 S_address  output  ADDR_W  address forwarded to slaves.
REQ-017 S_wr  output  1  write enable forwarded to slaves.
REQ-018 S_din  output  DATA_W  write data forwarded to slaves.
REQ-019 S_dout  input  N_SLAVE*DATA_W  packed slave read data (synchronous-read slaves).
REQ-020 decode_err  output  1  one-cycle pulse on an out-of-range access.

Function
REQ-021 Arbiter SHALL be a 2-state FSM: IDLE (M_grant = 0) and OWNED (exactly one M_grant bit set).
REQ-022 IDLE -> OWNED at the edge where any M_req is high; the winner is the first requester searched round-robin starting at (last_owner+1) mod N_MASTER.
REQ-023 OWNED holds while the owner's M_req is high; the grant never changes mid-request, except as REQ-036 allows.
REQ-024 Owner M_req low at an edge: if another request is pending, grant moves directly to the next round-robin winner (no idle cycle); otherwise OWNED -> IDLE.
REQ-025 last_owner SHALL update to the index of each newly granted master.
REQ-026 S_address, S_wr and S_din SHALL be combinational muxes of the granted master's signals; all zero in IDLE.
REQ-027 Slave index = S_address[ADDR_W-1:SLV_LSB]; S_sel[k] = 1 iff owner M_req is high and index == k < N_SLAVE.
REQ-028 An index >= N_SLAVE SHALL assert no S_sel, and SHALL pulse decode_err high for exactly the following cycle.
REQ-029 Read return latency SHALL be 1 cycle: the selected slave index is registered, and M_din = S_dout of that slave in the next cycle.
REQ-030 M_din SHALL be 0 in any cycle whose previous cycle had no S_sel asserted, or asserted S_wr.
REQ-031 A master SHALL use M_din only in the cycle after its own read; the bus does not tag return data.

Reset
REQ-032 While reset is high at an edge: M_grant = 0, FSM = IDLE, last_owner = N_MASTER-1 (master 0 wins first), registered read index invalid, decode_err = 0, hold counter = 0.
REQ-033 Reset asserted mid-transfer SHALL drop the grant at that edge; the in-flight read returns M_din = 0.
REQ-034 The first grant after reset release SHALL appear no earlier than the edge following the first sampled request.

Configuration
REQ-035 Macro BUS_RR_TIMEOUT_EN SHALL compile in a hold counter, counting consecutive OWNED cycles of the current owner.
REQ-036 With BUS_RR_TIMEOUT_EN: when the counter reaches MAX_HOLD and any other M_req is high, the grant moves to the next round-robin winner at that edge, and the counter clears on every grant change.
REQ-037 Without BUS_RR_TIMEOUT_EN: no counter exists, and an owner keeps the grant indefinitely while its M_req is high.

Verification
REQ-038 Reset, then M_req=4'b0101 -> M_grant=4'b0001 next edge; master 0 drops its request -> M_grant=4'b0100 at that edge with no idle cycle.
REQ-039 All four masters request continuously, each releasing after 1 cycle -> grant order 0,1,2,3,0.
REQ-040 Master 1 writes 0xDEADBEEF to 0x25 -> S_sel=4'b0010, S_address=0x25, S_wr=1; read of 0x25 -> M_din=0xDEADBEEF one cycle later.
REQ-041 Access to 0x80 -> S_sel=0, decode_err high for 1 cycle, and M_din=0 the next cycle.
REQ-042 BUS_RR_TIMEOUT_EN, MAX_HOLD=16: master 0 holds its request while master 2 requests -> grant moves to master 2 after 16 owned cycles; without the macro master 0 keeps the grant.
REQ-043 Reset asserted during an owned read -> M_grant=0 and M_din=0 the next cycle, and master 0 wins first afterwards.

Source files
------------

// File: rtl/bus_rr.sv
// bus_rr: round-robin multi-master bus with slave window decode and 1-cycle read return; BUS_RR_TIMEOUT_EN adds a MAX_HOLD grant limit
module bus_rr #(
  parameter int N_MASTER = 4,
  parameter int N_SLAVE  = 4,
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 32,
  parameter int SLV_LSB  = 5,
  parameter int MAX_HOLD = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [N_MASTER-1:0]          M_req,
  input  logic [N_MASTER-1:0]          M_wr,
  input  logic [N_MASTER*ADDR_W-1:0]   M_address,
  input  logic [N_MASTER*DATA_W-1:0]   M_dout,
  output logic [N_MASTER-1:0]          M_grant,
  output logic [DATA_W-1:0]            M_din,
  output logic [N_SLAVE-1:0]           S_sel,
  output logic [ADDR_W-1:0]            S_address,
  output logic                         S_wr,
  output logic [DATA_W-1:0]            S_din,
  input  logic [N_SLAVE*DATA_W-1:0]    S_dout,
  output logic                         decode_err
);
  localparam int MW = $clog2(N_MASTER);
  localparam int SW = ADDR_W - SLV_LSB;
  typedef enum logic {IDLE, OWNED} state_t;
  state_t state;
  logic [MW-1:0] last_owner, win;
  logic [N_MASTER-1:0] cand;
  logic [SW-1:0] sidx, rd_idx;
  logic own_req, win_ok, in_range, hit, tmo, sw, rd_valid;
  // last_owner doubles as the current owner while OWNED
  assign own_req   = state == OWNED && M_req[last_owner];
  assign cand      = M_req & ~M_grant;
  assign S_address = state == OWNED ? M_address[last_owner*ADDR_W +: ADDR_W] : '0;
  assign S_din     = state == OWNED ? M_dout[last_owner*DATA_W +: DATA_W] : '0;
  assign S_wr      = state == OWNED ? M_wr[last_owner] : 1'b0;
  assign sidx      = S_address[ADDR_W-1:SLV_LSB];
  assign in_range  = int'(sidx) < N_SLAVE;
  assign hit       = own_req && in_range;
  assign S_sel     = hit ? N_SLAVE'(1) << sidx : '0;
  assign M_din     = rd_valid ? S_dout[rd_idx*DATA_W +: DATA_W] : '0;
  assign sw        = state == IDLE || !M_req[last_owner] || tmo;
  // closest requester after last_owner wins, so scan from the far end down
  always_comb begin
    win_ok = 1'b0;
    win = '0;
    for (int i = N_MASTER; i >= 1; i--)
      for (int j = 0; j < N_MASTER; j++)
        if (cand[j] && j == (int'(last_owner) + i) % N_MASTER) begin
          win_ok = 1'b1;
          win = MW'(j);
        end
  end
`ifdef BUS_RR_TIMEOUT_EN
  localparam int HW = $clog2(MAX_HOLD + 1);
  logic [HW-1:0] hold;
  assign tmo = own_req && int'(hold) + 1 >= MAX_HOLD && |cand;
  always_ff @(posedge clk)
    if (reset || sw) hold <= '0;
    else if (int'(hold) < MAX_HOLD) hold <= hold + 1'b1;
`else
  assign tmo = MAX_HOLD < 0;
`endif
  always_ff @(posedge clk)
    if (reset) begin
      state      <= IDLE;
      M_grant    <= '0;
      last_owner <= MW'(N_MASTER - 1);
      rd_valid   <= 1'b0;
      rd_idx     <= '0;
      decode_err <= 1'b0;
    end else begin
      if (sw) begin
        state   <= win_ok ? OWNED : IDLE;
        M_grant <= win_ok ? N_MASTER'(1) << win : '0;
        if (win_ok) last_owner <= win;
      end
      rd_valid   <= hit && !S_wr;
      rd_idx     <= sidx;
      decode_err <= own_req && !in_range;
    end
endmodule
